rx_fc_drain_scheduler: RTL and testbench
========================================

// Module: rx_fc_drain_scheduler
// PURPOSE
//  Drains the six VC0 receive buffers (PH,PD,NPH,NPD,CH,CD) toward the transaction-layer consumer.
//  Round-robin arbitration over Posted/Non-posted/Completion classes; header then paired data beat.
//  Counts credits freed per buffer and schedules UpdateFC requests to the DLLP transmit path.
//  Sits between the VC0 receive element and the TL core / DLL flow-control logic.
// PARAMETERS
//  CNT_W       8   width of each freed-credit counter and of fc_upd_credits
//  UPD_THRESH  4   freed credits in one buffer that force an UpdateFC request
//  UPD_TIMEOUT 64  cycles with any nonzero counter before a forced UpdateFC (>=2)
//  TMR_W       7   timer width; must hold UPD_TIMEOUT
// PORTS
//  clk             in   1      clock, all logic on rising edge
//  rst             in   1      asynchronous reset, active-high
//  ph_empty..cd_empty in 1 each  empty flags of PH,PD,NPH,NPD,CH,CD buffers
//  p_has_data,np_has_data,c_has_data in 1 each  bit[2] of head header entry per class (FWFT)
//  ph_rd_en..cd_rd_en out 1 each read strobes to the six buffers
//  tl_valid        out  1      beat presented to TL this cycle
//  tl_class        out  2      00 posted, 01 non-posted, 10 completion
//  tl_is_data      out  1      0 header beat, 1 data beat
//  tl_ready        in   1      TL accepts beat when tl_valid&tl_ready
//  fc_upd_valid    out  1      UpdateFC request pending
//  fc_upd_type     out  3      buffer code: 000 PH,001 PD,010 NPH,011 NPD,100 CH,101 CD
//  fc_upd_credits  out  CNT_W  credits released in this update
//  fc_upd_ack      in   1      DLL consumed request this cycle
// BEHAVIOUR
//  Reset: all rd_en, tl_valid, tl_is_data, fc_upd_valid =0; tl_class=00; fc_upd_type=000;
//   fc_upd_credits=0; counters, timer =0; RR pointer=P; FSM=IDLE. rst mid-transfer aborts, no strobe.
//  FSM IDLE: class X eligible if hdr !empty and (!X_has_data or data !empty).
//   Pick first eligible starting at RR pointer (P->NP->CPL->P); none -> stay IDLE. Go HDR.
//  HDR: tl_valid=1, tl_is_data=0, tl_class=X (registered). On tl_ready: X hdr rd_en=1 same cycle;
//   next state DATA if X_has_data (sampled at grant) else IDLE; RR pointer = class after X.
//  DATA: tl_valid=1, tl_is_data=1. On tl_ready: X data rd_en=1; -> IDLE; pointer as above.
//  rd_en = tl_valid & tl_ready & selected buffer; combinational, never while buffer empty.
//  Latency: eligible in IDLE -> tl_valid next cycle; max throughput 1 TLP header per 2 cycles.
//  tl_class/tl_is_data held stable while tl_valid & !tl_ready.
//  Credit counters: one per buffer, +1 on each rd_en of that buffer; saturate at 2^CNT_W-1.
//  Request select (only when fc_upd_valid=0): lowest code with cnt>=UPD_THRESH; else if timer
//   reached UPD_TIMEOUT, lowest code with cnt!=0. Latch type and credits=cnt; valid next cycle.
//  Held stable until fc_upd_ack. On ack: cnt[type] <= cnt[type] - credits + (rd_en this cycle);
//   fc_upd_valid drops for >=1 cycle before next request.
//  Timer: counts while any cnt!=0 and no request pending; clears on ack or all-zero; saturates.
//  Simultaneous ack and increment on same buffer: both applied, no credit lost.
//  fc_upd_ack without fc_upd_valid: ignored.
// TESTING
//  1 Reset: rst=1 with all buffers non-empty -> all outputs 0, no rd_en; release -> tl_valid cycle 2.
//  2 P,NP,CPL headers (no data) always ready -> grants P,NP,CPL,P...; ph/nph/ch_rd_en one each.
//  3 p_has_data=1, pd_empty=1 while NP eligible -> NP served; P granted after pd_empty=0,
//    ph_rd_en then pd_rd_en on consecutive accepted beats.
//  4 tl_ready=0 for 5 cycles in HDR -> tl_valid held, class stable, zero rd_en; ready=1 -> one pulse.
//  5 4 PH reads -> fc_upd_valid, type=000, credits=4; ack same cycle as 5th ph_rd_en -> cnt=1.
//  6 1 CD read, idle -> request type=101, credits=1 after 64 timer cycles; ack -> timer clears.

Source files
------------

// File: rtl/rx_fc_drain_scheduler.sv
// VC0 receive drain: round-robin P/NP/CPL header+data beats toward the TL,
// with per-buffer freed-credit counters and UpdateFC request scheduling.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   *_empty                  empty flags of PH,PD,NPH,NPD,CH,CD buffers
//   p/np/c_has_data          head header carries a data payload (FWFT)
//   *_rd_en                  read strobes to the six buffers
//   tl_valid/class/is_data   beat presented to the TL, tl_ready accepts
//   fc_upd_valid/type/credits, fc_upd_ack   UpdateFC request handshake
module rx_fc_drain_scheduler #(
  parameter int CNT_W       = 8,
  parameter int UPD_THRESH  = 4,
  parameter int UPD_TIMEOUT = 64,
  parameter int TMR_W       = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ph_empty,
  input  logic             pd_empty,
  input  logic             nph_empty,
  input  logic             npd_empty,
  input  logic             ch_empty,
  input  logic             cd_empty,
  input  logic             p_has_data,
  input  logic             np_has_data,
  input  logic             c_has_data,
  output logic             ph_rd_en,
  output logic             pd_rd_en,
  output logic             nph_rd_en,
  output logic             npd_rd_en,
  output logic             ch_rd_en,
  output logic             cd_rd_en,
  output logic             tl_valid,
  output logic [1:0]       tl_class,
  output logic             tl_is_data,
  input  logic             tl_ready,
  output logic             fc_upd_valid,
  output logic [2:0]       fc_upd_type,
  output logic [CNT_W-1:0] fc_upd_credits,
  input  logic             fc_upd_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_DATA
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(UPD_THRESH);
  localparam logic [TMR_W-1:0] TMO     = TMR_W'(UPD_TIMEOUT);

  state_t state_q, state_d;
  logic [1:0] cls_q, cls_d;
  logic [1:0] rr_q, rr_d;
  logic       hd_q, hd_d;

  logic             upd_valid_q, upd_valid_d;
  logic [2:0]       upd_type_q, upd_type_d;
  logic [CNT_W-1:0] upd_cred_q, upd_cred_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];

  logic [3:0] elig;
  logic [3:0] has_data;
  logic [1:0] c0, c1, c2;
  logic [1:0] gsel;
  logic       gany;
  logic       hdr_acc, dat_acc;
  logic [5:0] rd;

  function automatic logic [1:0] nxt_cls(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // bit index = class code (0 P, 1 NP, 2 CPL); bit 3 is a never-eligible pad
  assign has_data = {1'b0, c_has_data, np_has_data, p_has_data};
  assign elig[0] = ~ph_empty  & (~p_has_data  | ~pd_empty);
  assign elig[1] = ~nph_empty & (~np_has_data | ~npd_empty);
  assign elig[2] = ~ch_empty  & (~c_has_data  | ~cd_empty);
  assign elig[3] = 1'b0;

  // rotating priority starting at the RR pointer
  assign c0 = rr_q;
  assign c1 = nxt_cls(c0);
  assign c2 = nxt_cls(c1);

  always_comb begin
    gany = 1'b1;
    gsel = c0;
    if (elig[c0])      gsel = c0;
    else if (elig[c1]) gsel = c1;
    else if (elig[c2]) gsel = c2;
    else               gany = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    hd_d    = hd_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (gany) begin
          state_d = S_HDR;
          cls_d   = gsel;
          hd_d    = has_data[gsel];
        end
      end
      S_HDR: begin
        if (tl_ready) begin
          state_d = hd_q ? S_DATA : S_IDLE;
          rr_d    = nxt_cls(cls_q);
        end
      end
      S_DATA: begin
        if (tl_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= 2'd0;
      hd_q    <= 1'b0;
      rr_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      hd_q    <= hd_d;
      rr_q    <= rr_d;
    end
  end

  assign tl_valid   = (state_q != S_IDLE);
  assign tl_is_data = (state_q == S_DATA);
  assign tl_class   = cls_q;

  assign hdr_acc = (state_q == S_HDR)  & tl_ready;
  assign dat_acc = (state_q == S_DATA) & tl_ready;

  assign ph_rd_en  = hdr_acc & (cls_q == 2'd0);
  assign pd_rd_en  = dat_acc & (cls_q == 2'd0);
  assign nph_rd_en = hdr_acc & (cls_q == 2'd1);
  assign npd_rd_en = dat_acc & (cls_q == 2'd1);
  assign ch_rd_en  = hdr_acc & (cls_q == 2'd2);
  assign cd_rd_en  = dat_acc & (cls_q == 2'd2);

  assign rd = {cd_rd_en, ch_rd_en, npd_rd_en,
               nph_rd_en, pd_rd_en, ph_rd_en};

  // ack subtracts the reported credits but keeps a same-cycle read
  always_comb begin
    logic [CNT_W-1:0] base;
    base = '0;
    for (int i = 0; i < 6; i++) begin
      base = cnt_q[i];
      if (upd_valid_q && fc_upd_ack && upd_type_q == 3'(i))
        base = cnt_q[i] - upd_cred_q;
      cnt_d[i] = (rd[i] && base != CNT_MAX) ? base + 1'b1 : base;
    end
  end

  logic             thr_hit, nz_hit;
  logic [2:0]       thr_sel, nz_sel;
  logic [CNT_W-1:0] thr_cred, nz_cred;

  // descending scan so the lowest qualifying code wins
  always_comb begin
    thr_hit  = 1'b0;
    thr_sel  = 3'd0;
    thr_cred = '0;
    nz_hit   = 1'b0;
    nz_sel   = 3'd0;
    nz_cred  = '0;
    for (int i = 5; i >= 0; i--) begin
      if (cnt_q[i] >= THRESH) begin
        thr_hit  = 1'b1;
        thr_sel  = 3'(i);
        thr_cred = cnt_q[i];
      end
      if (cnt_q[i] != '0) begin
        nz_hit  = 1'b1;
        nz_sel  = 3'(i);
        nz_cred = cnt_q[i];
      end
    end
  end

  always_comb begin
    upd_valid_d = upd_valid_q;
    upd_type_d  = upd_type_q;
    upd_cred_d  = upd_cred_q;
    tmr_d       = tmr_q;
    if (upd_valid_q) begin
      if (fc_upd_ack) upd_valid_d = 1'b0;
    end else if (thr_hit) begin
      upd_valid_d = 1'b1;
      upd_type_d  = thr_sel;
      upd_cred_d  = thr_cred;
    end else if (tmr_q >= TMO && nz_hit) begin
      upd_valid_d = 1'b1;
      upd_type_d  = nz_sel;
      upd_cred_d  = nz_cred;
    end
    if ((upd_valid_q && fc_upd_ack) || !nz_hit)
      tmr_d = '0;
    else if (!upd_valid_q && tmr_q < TMO)
      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      upd_type_q  <= 3'd0;
      upd_cred_q  <= '0;
      tmr_q       <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      upd_valid_q <= upd_valid_d;
      upd_type_q  <= upd_type_d;
      upd_cred_q  <= upd_cred_d;
      tmr_q       <= tmr_d;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign fc_upd_valid   = upd_valid_q;
  assign fc_upd_type    = upd_type_q;
  assign fc_upd_credits = upd_cred_q;

endmodule

// File: tb/tb_rx_fc_drain_scheduler.sv
// Bench for rx_fc_drain_scheduler: emulated buffers, beat scoreboard,
// and a credit-count model checked against every UpdateFC request.
module tb_rx_fc_drain_scheduler;

  typedef struct packed {
    logic [1:0] cls;
    logic       isd;
  } beat_t;

  logic       clk, rst;
  logic       ph_empty, pd_empty, nph_empty, npd_empty, ch_empty, cd_empty;
  logic       p_has_data, np_has_data, c_has_data;
  logic       ph_rd_en, pd_rd_en, nph_rd_en, npd_rd_en, ch_rd_en, cd_rd_en;
  logic       tl_valid, tl_is_data, tl_ready;
  logic [1:0] tl_class;
  logic       fc_upd_valid, fc_upd_ack;
  logic [2:0] fc_upd_type;
  logic [7:0] fc_upd_credits;

  rx_fc_drain_scheduler dut (
    .clk(clk), .rst(rst),
    .ph_empty(ph_empty), .pd_empty(pd_empty),
    .nph_empty(nph_empty), .npd_empty(npd_empty),
    .ch_empty(ch_empty), .cd_empty(cd_empty),
    .p_has_data(p_has_data), .np_has_data(np_has_data),
    .c_has_data(c_has_data),
    .ph_rd_en(ph_rd_en), .pd_rd_en(pd_rd_en),
    .nph_rd_en(nph_rd_en), .npd_rd_en(npd_rd_en),
    .ch_rd_en(ch_rd_en), .cd_rd_en(cd_rd_en),
    .tl_valid(tl_valid), .tl_class(tl_class),
    .tl_is_data(tl_is_data), .tl_ready(tl_ready),
    .fc_upd_valid(fc_upd_valid), .fc_upd_type(fc_upd_type),
    .fc_upd_credits(fc_upd_credits), .fc_upd_ack(fc_upd_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int checks;
  int errors;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // emulated receive buffers: header ring per class, data count per class
  bit         hd [3][64];
  logic [5:0] hh [3];
  logic [5:0] ht [3];
  int         dc [3];

  assign ph_empty    = (hh[0] == ht[0]);
  assign nph_empty   = (hh[1] == ht[1]);
  assign ch_empty    = (hh[2] == ht[2]);
  assign pd_empty    = (dc[0] == 0);
  assign npd_empty   = (dc[1] == 0);
  assign cd_empty    = (dc[2] == 0);
  assign p_has_data  = hd[0][hh[0]];
  assign np_has_data = hd[1][hh[1]];
  assign c_has_data  = hd[2][hh[2]];

  beat_t exp_q[$];

  function automatic beat_t mk(input int c, input bit d);
    beat_t b;
    b.cls = 2'(c);
    b.isd = d;
    return b;
  endfunction

  task automatic add_hdr(input int c, input bit has, input bit with_data);
    hd[c][ht[c]] = has;
    ht[c] = ht[c] + 6'd1;
    if (has && with_data) dc[c]++;
  endtask

  // expected service order of the loaded headers, pointer starting at P
  task automatic push_rr_order();
    logic [5:0] h [3];
    int p;
    int f;
    p = 0;
    for (int c = 0; c < 3; c++) h[c] = hh[c];
    for (int n = 0; n < 200; n++) begin
      f = -1;
      for (int k = 0; k < 3; k++)
        if (f < 0 && h[(p + k) % 3] != ht[(p + k) % 3]) f = (p + k) % 3;
      if (f < 0) break;
      exp_q.push_back(mk(f, 1'b0));
      if (hd[f][h[f]]) exp_q.push_back(mk(f, 1'b1));
      h[f] = h[f] + 6'd1;
      p = (f + 1) % 3;
    end
  endtask

  bit rand_ready;
  bit auto_ack;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) tl_ready = ($urandom_range(0, 3) != 0);
    if (auto_ack) fc_upd_ack = ($urandom_range(0, 2) == 0);
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    auto_ack   = 1'b0;
    tl_ready   = 1'b0;
    fc_upd_ack = 1'b0;
    rst        = 1'b1;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      hh[c] = '0;
      ht[c] = '0;
      dc[c] = 0;
    end
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) chk(nm, exp_q.size(), 0);
  endtask

  task automatic wait_upd(input string nm, input int max);
    for (int i = 0; i < max && !fc_upd_valid; i++) step();
    if (!fc_upd_valid) chk(nm, 0, 1);
  endtask

  // monitor: pops scoreboard on accepted beats, keeps credit model
  int  mcnt [6];
  int  s1 [6];
  int  s2 [6];
  int  exp_type, exp_cred;
  bit  prev_uv, prev_ackd, prev_stall;
  logic [1:0] prev_cls;
  logic       prev_isd;
  int  last_beat_cyc;

  always @(negedge clk) begin
    logic [5:0] rdv;
    beat_t b;
    int code;
    int sel;
    rdv = {cd_rd_en, ch_rd_en, npd_rd_en, nph_rd_en, pd_rd_en, ph_rd_en};
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        mcnt[i] = 0;
        s1[i] = 0;
        s2[i] = 0;
      end
      prev_uv    = 1'b0;
      prev_ackd  = 1'b0;
      prev_stall = 1'b0;
      exp_type   = -1;
      exp_cred   = -1;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", tl_valid, 1);
        chk("hold_class", tl_class, prev_cls);
        chk("hold_isdata", tl_is_data, prev_isd);
      end
      code = -1;
      if (tl_valid && tl_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", tl_class, -1);
        end else begin
          b = exp_q.pop_front();
          chk("beat_class", tl_class, b.cls);
          chk("beat_isdata", tl_is_data, b.isd);
          code = b.cls * 2 + b.isd;
          chk("beat_rd_en", rdv, 1 << code);
          if (b.isd) dc[b.cls]--;
          else hh[b.cls] = hh[b.cls] + 6'd1;
          last_beat_cyc = cyc;
        end
      end else begin
        chk("idle_rd_en", rdv, 0);
      end
      if (prev_ackd) chk("upd_gap", fc_upd_valid, 0);
      if (fc_upd_valid && !prev_uv) begin
        // request reflects counts two samples back (select, then register)
        sel = -1;
        for (int i = 5; i >= 0; i--) if (s2[i] >= 4) sel = i;
        if (sel < 0)
          for (int i = 5; i >= 0; i--) if (s2[i] != 0) sel = i;
        exp_type = sel;
        exp_cred = (sel >= 0) ? s2[sel] : -1;
        chk("upd_type", fc_upd_type, exp_type);
        chk("upd_credits", fc_upd_credits, exp_cred);
      end else if (fc_upd_valid) begin
        chk("upd_type_held", fc_upd_type, exp_type);
        chk("upd_cred_held", fc_upd_credits, exp_cred);
      end
      if (code >= 0 && mcnt[code] < 255) mcnt[code]++;
      if (fc_upd_valid && fc_upd_ack && exp_type >= 0)
        mcnt[exp_type] -= exp_cred;
      prev_ackd  = fc_upd_valid && fc_upd_ack;
      prev_uv    = fc_upd_valid;
      prev_stall = tl_valid && !tl_ready;
      prev_cls   = tl_class;
      prev_isd   = tl_is_data;
      s2 = s1;
      s1 = mcnt;
    end
  end

  int lat, ack_cyc, n;

  initial begin
    checks = 0;
    errors = 0;
    rand_ready = 1'b0;
    auto_ack   = 1'b0;
    tl_ready   = 1'b0;
    fc_upd_ack = 1'b0;
    rst        = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hh[c] = '0;
      ht[c] = '0;
      dc[c] = 0;
    end

    // reset with every buffer non-empty
    for (int c = 0; c < 3; c++) add_hdr(c, 1'b1, 1'b1);
    repeat (3) begin
      step();
      chk("reset_outs",
          {tl_valid, tl_is_data, tl_class, ph_rd_en, pd_rd_en, nph_rd_en,
           npd_rd_en, ch_rd_en, cd_rd_en, fc_upd_valid, fc_upd_type,
           fc_upd_credits}, 0);
    end
    rst = 1'b0;
    chk("release_cyc1_valid", tl_valid, 0);
    step();
    chk("release_cyc2_valid", tl_valid, 1);
    chk("release_cyc2_class", tl_class, 0);
    step();
    rst = 1'b1;
    tl_ready = 1'b1;
    #1;
    chk("abort_outs",
        {tl_valid, tl_is_data, ph_rd_en, pd_rd_en, nph_rd_en,
         npd_rd_en, ch_rd_en, cd_rd_en}, 0);

    // headers only, always ready: P,NP,CPL,P,NP,CPL
    do_reset();
    tl_ready = 1'b1;
    auto_ack = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) add_hdr(c, 1'b0, 1'b0);
    push_rr_order();
    wait_drain("drain_rr", 100);

    // P waits on missing data while NP is served
    do_reset();
    tl_ready = 1'b1;
    auto_ack = 1'b1;
    add_hdr(0, 1'b1, 1'b0);
    add_hdr(1, 1'b0, 1'b0);
    exp_q.push_back(mk(1, 1'b0));
    exp_q.push_back(mk(0, 1'b0));
    exp_q.push_back(mk(0, 1'b1));
    for (int i = 0; i < 20 && exp_q.size() > 2; i++) step();
    repeat (4) step();
    chk("p_blocked_no_data", exp_q.size(), 2);
    dc[0] = 1;
    wait_drain("drain_p_data", 50);

    // stall in HDR for 5 cycles
    do_reset();
    add_hdr(2, 1'b0, 1'b0);
    exp_q.push_back(mk(2, 1'b0));
    for (int i = 0; i < 10 && !tl_valid; i++) step();
    repeat (5) begin
      step();
      chk("stall_valid", tl_valid, 1);
      chk("stall_class", tl_class, 2);
      chk("stall_rd_en", {ph_rd_en, pd_rd_en, nph_rd_en, npd_rd_en,
                          ch_rd_en, cd_rd_en}, 0);
    end
    tl_ready = 1'b1;
    #1;
    chk("stall_release_ch_rd", ch_rd_en, 1);
    step();
    chk("stall_one_pulse", ch_rd_en, 0);
    wait_drain("drain_stall", 10);

    // threshold request, ack together with the 5th PH read
    do_reset();
    tl_ready = 1'b1;
    for (int i = 0; i < 5; i++) add_hdr(0, 1'b0, 1'b0);
    push_rr_order();
    wait_upd("thresh_upd_seen", 40);
    chk("thresh_with_5th_read", ph_rd_en, 1);
    chk("thresh_beats_left", exp_q.size(), 1);
    chk("thresh_type", fc_upd_type, 0);
    chk("thresh_credits", fc_upd_credits, 4);
    fc_upd_ack = 1'b1;
    step();
    fc_upd_ack = 1'b0;
    wait_drain("drain_thresh", 20);
    wait_upd("residual_upd_seen", 100);
    chk("residual_type", fc_upd_type, 0);
    chk("residual_credits", fc_upd_credits, 1);
    fc_upd_ack = 1'b1;
    step();
    fc_upd_ack = 1'b0;

    // timeout requests for one CH + one CD read
    do_reset();
    tl_ready = 1'b1;
    add_hdr(2, 1'b1, 1'b1);
    push_rr_order();
    wait_drain("drain_cpl", 20);
    wait_upd("tmo_upd_seen", 100);
    lat = cyc - last_beat_cyc;
    chk_rng("tmo_latency", lat, 64, 66);
    chk("tmo_type_ch", fc_upd_type, 4);
    chk("tmo_credits_ch", fc_upd_credits, 1);
    fc_upd_ack = 1'b1;
    ack_cyc = cyc;
    step();
    fc_upd_ack = 1'b0;
    wait_upd("tmo2_upd_seen", 100);
    lat = cyc - ack_cyc;
    chk_rng("tmo_after_ack_latency", lat, 65, 67);
    chk("tmo_type_cd", fc_upd_type, 5);
    chk("tmo_credits_cd", fc_upd_credits, 1);
    fc_upd_ack = 1'b1;
    step();
    fc_upd_ack = 0;

    // randomized loads, random ready and ack
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 3; c++) begin
        n = $urandom_range(4, 15);
        for (int i = 0; i < n; i++)
          add_hdr(c, 1'($urandom_range(0, 1)), 1'b1);
      end
      push_rr_order();
      rand_ready = 1'b1;
      auto_ack   = 1'b1;
      wait_drain("drain_random", 1000);
      repeat (300) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
